// File: rtl/uart_tx_fifo_if.sv
// Host-side signal bundle for uart_tx_fifo: write port, frame config and line/status outputs.
// Tx_BREAK is present only when UART_TX_BREAK_EN is defined.
interface uart_tx_fifo_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DIV_W  = 16
);
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic              Tx_EN;
    logic              Tx_WR;
    logic [DATA_W-1:0] Tx_DATA;
    logic [DIV_W-1:0]  baud_div;
    logic [3:0]        nbits;
    logic [1:0]        parity_mode;
    logic              stop2;
`ifdef UART_TX_BREAK_EN
    logic              Tx_BREAK;
`endif
    logic              TxD;
    logic              Tx_BUSY;
    logic              Tx_DONE;
    logic              Tx_FULL;
    logic              Tx_EMPTY;
    logic [LVL_W-1:0]  Tx_LEVEL;
    logic              Tx_OVF;

    modport master (
`ifdef UART_TX_BREAK_EN
        output Tx_BREAK,
`endif
        output Tx_EN, Tx_WR, Tx_DATA, baud_div, nbits, parity_mode, stop2,
        input  TxD, Tx_BUSY, Tx_DONE, Tx_FULL, Tx_EMPTY, Tx_LEVEL, Tx_OVF
    );

    modport slave (
`ifdef UART_TX_BREAK_EN
        input  Tx_BREAK,
`endif
        input  Tx_EN, Tx_WR, Tx_DATA, baud_div, nbits, parity_mode, stop2,
        output TxD, Tx_BUSY, Tx_DONE, Tx_FULL, Tx_EMPTY, Tx_LEVEL, Tx_OVF
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: write FIFO, internal prescaler/oversample bit timer, runtime frame format.
// Define UART_TX_BREAK_EN to add the Tx_BREAK input and the BREAK line state.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16
) (
    input logic           clk,
    input logic           reset,
    uart_tx_fifo_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned OS_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    typedef enum logic [2:0] {
        S_OFF,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
`ifdef UART_TX_BREAK_EN
        , S_BREAK
`endif
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              full_q, empty_q, ovf_q;
    logic              push, pop;
    logic [DATA_W-1:0] head;

    logic [DATA_W-1:0] shift_q, shift_d;
    logic [3:0]        nbits_q, nbits_d, nbits_eff;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic              par_en_q, par_en_d, par_bit_q, par_bit_d, par_calc;
    logic              stop2_q, stop2_d, stop_cnt_q, stop_cnt_d;
    logic [DIV_W-1:0]  bd_q, bd_d, presc_q, presc_d;
    logic [OS_W-1:0]   os_q, os_d;
    logic              tick, bit_end;
    logic              txd_q, txd_d, busy_q, busy_d, done_q, done_d;
`ifdef UART_TX_BREAK_EN
    logic              brk_rel_q, brk_rel_d;
`endif

    // Write FIFO; a write while full is dropped even if a pop frees a slot on the same edge
    assign push    = bus.Tx_WR && !full_q;
    assign head    = mem[rd_ptr_q];
    assign count_d = count_q + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.Tx_DATA;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            full_q  <= (count_d == LVL_W'(DEPTH));
            empty_q <= (count_d == '0);
            ovf_q   <= bus.Tx_WR && full_q;
        end
    end

    // Effective data width and parity of the head word, sampled when a frame is launched
    always_comb begin
        nbits_eff = (bus.nbits >= 4'd5 && bus.nbits <= 4'(DATA_W)) ? bus.nbits : 4'(DATA_W);
        par_calc  = 1'b0;
        for (int i = 0; i < int'(DATA_W); i++) begin
            if (4'(i) < nbits_eff) par_calc = par_calc ^ head[i];
        end
    end

    assign tick    = (presc_q == bd_q);
    assign bit_end = tick && (os_q == OS_W'(OVERSAMPLE - 1));

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        nbits_d    = nbits_q;
        bit_cnt_d  = bit_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        stop2_d    = stop2_q;
        stop_cnt_d = stop_cnt_q;
        bd_d       = bd_q;
        presc_d    = tick ? '0 : presc_q + DIV_W'(1);
        os_d       = bit_end ? '0 : (tick ? os_q + OS_W'(1) : os_q);
        pop        = 1'b0;
        done_d     = 1'b0;
        txd_d      = 1'b1;
        busy_d     = 1'b1;
`ifdef UART_TX_BREAK_EN
        brk_rel_d  = brk_rel_q;
`endif
        case (state_q)
            S_OFF: begin
                presc_d = '0;
                os_d    = '0;
                if (bus.Tx_EN) state_d = S_IDLE;
            end
            S_IDLE: begin
                presc_d = '0;
                os_d    = '0;
                if (!bus.Tx_EN) begin
                    state_d = S_OFF;
`ifdef UART_TX_BREAK_EN
                end else if (bus.Tx_BREAK) begin
                    bd_d      = bus.baud_div;
                    brk_rel_d = 1'b0;
                    state_d   = S_BREAK;
`endif
                end else if (!empty_q) begin
                    pop        = 1'b1;
                    shift_d    = head;
                    nbits_d    = nbits_eff;
                    bit_cnt_d  = '0;
                    par_en_d   = (bus.parity_mode == 2'b01) || (bus.parity_mode == 2'b10);
                    par_bit_d  = (bus.parity_mode == 2'b10) ? ~par_calc : par_calc;
                    stop2_d    = bus.stop2;
                    stop_cnt_d = 1'b0;
                    bd_d       = bus.baud_div;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == nbits_q - 4'd1) state_d = par_en_q ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            // Hold the line low with the timer parked; release arms one stop bit
            S_BREAK: begin
                if (!brk_rel_q) begin
                    presc_d = '0;
                    os_d    = '0;
                    if (!bus.Tx_BREAK) brk_rel_d = 1'b1;
                end else if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_OFF;
        endcase

        // Line and busy follow the state being entered so TxD changes on the transition edge
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
            S_PARITY: txd_d = par_bit_d;
            S_STOP:   txd_d = 1'b1;
`ifdef UART_TX_BREAK_EN
            S_BREAK:  txd_d = brk_rel_d;
`endif
            default:  busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_OFF;
            shift_q    <= '0;
            nbits_q    <= 4'(DATA_W);
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
            stop_cnt_q <= 1'b0;
            bd_q       <= '0;
            presc_q    <= '0;
            os_q       <= '0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_BREAK_EN
            brk_rel_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            nbits_q    <= nbits_d;
            bit_cnt_q  <= bit_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            stop2_q    <= stop2_d;
            stop_cnt_q <= stop_cnt_d;
            bd_q       <= bd_d;
            presc_q    <= presc_d;
            os_q       <= os_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_BREAK_EN
            brk_rel_q  <= brk_rel_d;
`endif
        end
    end

    assign bus.TxD      = txd_q;
    assign bus.Tx_BUSY  = busy_q;
    assign bus.Tx_DONE  = done_q;
    assign bus.Tx_FULL  = full_q;
    assign bus.Tx_EMPTY = empty_q;
    assign bus.Tx_LEVEL = count_q;
    assign bus.Tx_OVF   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a line monitor decodes frames against a scoreboard of queued words.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DIV_W  = 16;
    localparam int unsigned OS_A   = 16;
    localparam int unsigned OS_B   = 1;

    typedef struct packed {
        logic [7:0]  data;
        logic [3:0]  nbits;
        logic [1:0]  pm;
        logic        stop2;
        logic [15:0] bd;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) a ();
    uart_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DIV_W(DIV_W)) b ();

    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVERSAMPLE(OS_A), .DIV_W(DIV_W)) dut_a (
        .clk(clk), .reset(reset), .bus(a));
    uart_tx_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .OVERSAMPLE(OS_B), .DIV_W(DIV_W)) dut_b (
        .clk(clk), .reset(reset), .bus(b));

    frame_t sb_q[$];
    logic   bq[$];
    int     starts[$];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     cyc      = 0;
    int     done_cnt = 0;
    logic   mon_en   = 1'b0;
    logic   mon_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic frame_t mk(input logic [7:0] d, input logic [3:0] nb, input logic [1:0] pm,
                                  input logic s2, input logic [15:0] bd);
        frame_t f;
        f.data = d; f.nbits = nb; f.pm = pm; f.stop2 = s2; f.bd = bd;
        return f;
    endfunction

    // Reference line sequence: start, nbits LSB-first, optional parity, 1 or 2 stops
    function automatic int frame_bits(input frame_t f, output logic [15:0] bits);
        int  nb;
        int  n;
        logic p;
        nb = (int'(f.nbits) >= 5 && int'(f.nbits) <= int'(DATA_W)) ? int'(f.nbits) : int'(DATA_W);
        bits = '1;
        bits[0] = 1'b0;
        p = 1'b0;
        n = 1;
        for (int i = 0; i < nb; i++) begin
            bits[n] = f.data[i];
            p = p ^ f.data[i];
            n++;
        end
        if (f.pm == 2'b01) begin bits[n] = p;  n++; end
        else if (f.pm == 2'b10) begin bits[n] = ~p; n++; end
        n += f.stop2 ? 2 : 1;
        return n;
    endfunction

    always @(posedge clk) cyc = cyc + 1;
    always @(negedge clk) if (a.Tx_DONE === 1'b1) done_cnt = done_cnt + 1;

    initial begin : monitor_a
        frame_t      f;
        logic [15:0] bits;
        int          n;
        int          t;
        forever begin
            @(negedge clk);
            if (mon_en && reset === 1'b1 && a.TxD === 1'b0) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_start", 32'(a.TxD), 32'(1));
                end else begin
                    mon_busy = 1'b1;
                    starts.push_back(cyc);
                    f = sb_q.pop_front();
                    n = frame_bits(f, bits);
                    t = (int'(f.bd) + 1) * int'(OS_A);
                    for (int c = 0; c <= n * t; c++) begin
                        if (c > 0) @(negedge clk);
                        if (c % t == t / 2)
                            check_eq($sformatf("txd_bit%0d_d%0h", c / t, f.data), 32'(a.TxD), 32'(bits[c / t]));
                        if (c == t / 2) check_eq("busy_in_frame", 32'(a.Tx_BUSY), 32'(1));
                        if (c == n * t - 1) check_eq("done_early", 32'(a.Tx_DONE), 32'(0));
                        if (c == n * t) begin
                            check_eq("done_pulse", 32'(a.Tx_DONE), 32'(1));
                            check_eq("busy_after", 32'(a.Tx_BUSY), 32'(0));
                        end
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic write_a(input logic [7:0] d);
        @(negedge clk);
        a.Tx_DATA = d;
        a.Tx_WR   = 1'b1;
        @(negedge clk);
        a.Tx_WR   = 1'b0;
    endtask

    task automatic write_b(input logic [7:0] d);
        @(negedge clk);
        b.Tx_DATA = d;
        b.Tx_WR   = 1'b1;
        @(negedge clk);
        b.Tx_WR   = 1'b0;
    endtask

    task automatic wait_start_a(input int maxc);
        int c = 0;
        while (a.TxD !== 1'b0 && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (c >= maxc) check_eq("start_timeout", 32'(a.TxD), 32'(0));
    endtask

    task automatic wait_drain(input int maxc);
        int c = 0;
        while (!(sb_q.size() == 0 && !mon_busy && a.Tx_BUSY === 1'b0) && c < maxc) begin
            @(negedge clk);
            c++;
        end
        if (c >= maxc) check_eq("drain_timeout", 32'(sb_q.size()), 32'(0));
        @(negedge clk);
    endtask

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        frame_t      f;
        logic [15:0] bits;
        int          n;
        int          c;
        int          d0;

        reset = 1'b0;
        a.Tx_EN = 1'b0; a.Tx_WR = 1'b0; a.Tx_DATA = '0; a.baud_div = '0;
        a.nbits = 4'd8; a.parity_mode = 2'b00; a.stop2 = 1'b0;
        b.Tx_EN = 1'b1; b.Tx_WR = 1'b0; b.Tx_DATA = '0; b.baud_div = '0;
        b.nbits = 4'd5; b.parity_mode = 2'b00; b.stop2 = 1'b0;
`ifdef UART_TX_BREAK_EN
        a.Tx_BREAK = 1'b0;
        b.Tx_BREAK = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_eq("rst_txd",   32'(a.TxD),      32'(1));
        check_eq("rst_busy",  32'(a.Tx_BUSY),  32'(0));
        check_eq("rst_done",  32'(a.Tx_DONE),  32'(0));
        check_eq("rst_full",  32'(a.Tx_FULL),  32'(0));
        check_eq("rst_empty", 32'(a.Tx_EMPTY), 32'(1));
        check_eq("rst_level", 32'(a.Tx_LEVEL), 32'(0));
        check_eq("rst_ovf",   32'(a.Tx_OVF),   32'(0));
        reset = 1'b1;

        // Reset mid-frame during data bit 3 of 0xA5 (bit 3 is 0)
        a.baud_div = 16'd1; a.nbits = 4'd8; a.parity_mode = 2'b01; a.stop2 = 1'b0;
        a.Tx_EN = 1'b1;
        repeat (2) @(negedge clk);
        write_a(8'hA5);
        wait_start_a(20);
        repeat (4 * 32 + 16) @(negedge clk);
        check_eq("sc1_txd_before",  32'(a.TxD),     32'(0));
        check_eq("sc1_busy_before", 32'(a.Tx_BUSY), 32'(1));
        #2 reset = 1'b0;
        #1;
        check_eq("sc1_txd",   32'(a.TxD),      32'(1));
        check_eq("sc1_busy",  32'(a.Tx_BUSY),  32'(0));
        check_eq("sc1_empty", 32'(a.Tx_EMPTY), 32'(1));
        check_eq("sc1_level", 32'(a.Tx_LEVEL), 32'(0));
        @(negedge clk);
        reset = 1'b1;
        mon_en = 1'b1;

        // Single even-parity frame; config changes mid-frame must not apply
        sb_q.push_back(mk(8'hA5, 4'd8, 2'b01, 1'b0, 16'd1));
        write_a(8'hA5);
        wait_start_a(20);
        @(negedge clk);
        a.parity_mode = 2'b00; a.stop2 = 1'b1; a.nbits = 4'd5;
        wait_drain(1000);

        // Odd parity, 7 data bits, two stops
        a.nbits = 4'd7; a.parity_mode = 2'b10; a.stop2 = 1'b1;
        sb_q.push_back(mk(8'h01, 4'd7, 2'b10, 1'b1, 16'd1));
        write_a(8'h01);
        wait_drain(1000);

        // Fill with transmitter disabled, overflow on the fifth write, then drain back-to-back
        a.Tx_EN = 1'b0; a.baud_div = 16'd0; a.nbits = 4'd8; a.parity_mode = 2'b00; a.stop2 = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) write_a(8'(17 * (i + 1)));
        check_eq("sc4_level", 32'(a.Tx_LEVEL), 32'(4));
        check_eq("sc4_full",  32'(a.Tx_FULL),  32'(1));
        check_eq("sc4_empty", 32'(a.Tx_EMPTY), 32'(0));
        check_eq("sc4_ovf0",  32'(a.Tx_OVF),   32'(0));
        write_a(8'h55);
        check_eq("sc4_ovf",     32'(a.Tx_OVF),   32'(1));
        check_eq("sc4_level_5", 32'(a.Tx_LEVEL), 32'(4));
        @(negedge clk);
        check_eq("sc4_ovf_pulse", 32'(a.Tx_OVF), 32'(0));
        check_eq("sc4_idle_txd",  32'(a.TxD),    32'(1));
        for (int i = 0; i < 4; i++) sb_q.push_back(mk(8'(17 * (i + 1)), 4'd8, 2'b00, 1'b0, 16'd0));
        d0 = done_cnt;
        starts.delete();
        a.Tx_EN = 1'b1;
        wait_drain(1500);
        check_eq("sc4_done_cnt", 32'(done_cnt - d0), 32'(4));
        check_eq("sc4_empty_end", 32'(a.Tx_EMPTY), 32'(1));
        check_eq("sc4_starts", 32'(starts.size()), 32'(4));
        for (int i = 0; i + 1 < starts.size(); i++)
            check_eq($sformatf("sc4_gap%0d", i), 32'(starts[i + 1] - starts[i]), 32'(161));

        // Enable dropped during the parity bit with two words queued
        a.parity_mode = 2'b01;
        a.Tx_EN = 1'b0;
        repeat (2) @(negedge clk);
        write_a(8'h3C);
        write_a(8'hC3);
        sb_q.push_back(mk(8'h3C, 4'd8, 2'b01, 1'b0, 16'd0));
        a.Tx_EN = 1'b1;
        wait_start_a(20);
        repeat (9 * 16 + 8) @(negedge clk);
        a.Tx_EN = 1'b0;
        wait_drain(500);
        repeat (20) @(negedge clk);
        check_eq("sc5_txd",   32'(a.TxD),      32'(1));
        check_eq("sc5_busy",  32'(a.Tx_BUSY),  32'(0));
        check_eq("sc5_level", 32'(a.Tx_LEVEL), 32'(1));
        sb_q.push_back(mk(8'hC3, 4'd8, 2'b01, 1'b0, 16'd0));
        a.Tx_EN = 1'b1;
        wait_drain(500);
        check_eq("sc5_empty_end", 32'(a.Tx_EMPTY), 32'(1));

        // One clock per bit, no parity, 5 data bits on the OVERSAMPLE=1 instance
        f = mk(8'h1F, 4'd5, 2'b00, 1'b0, 16'd0);
        n = frame_bits(f, bits);
        for (int i = 0; i < n; i++) bq.push_back(bits[i]);
        write_b(8'h1F);
        c = 0;
        while (b.TxD !== 1'b0 && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (c >= 20) check_eq("sc6_start_timeout", 32'(b.TxD), 32'(0));
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clk);
            if (k < n) begin
                check_eq($sformatf("sc6_txd%0d", k), 32'(b.TxD), 32'(bq.pop_front()));
                check_eq($sformatf("sc6_busy%0d", k), 32'(b.Tx_BUSY), 32'(1));
            end else begin
                check_eq("sc6_busy_end", 32'(b.Tx_BUSY), 32'(0));
                check_eq("sc6_done",     32'(b.Tx_DONE), 32'(1));
                check_eq("sc6_txd_end",  32'(b.TxD),     32'(1));
            end
        end
        check_eq("sc6_len", 32'(n), 32'(7));

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an internal write FIFO and runtime-selectable frame format (data width, parity mode, stop bits). It replaces the fixed 8-bit, even-parity, unbuffered transmitter. Bit timing comes from an internal prescaler and oversample counter, so no external baud controller instance is needed. The host pushes bytes with Tx_WR; the block drains the FIFO back-to-back onto TxD.

Parameters:
DATA_W, 8, maximum data bits per frame; legal range 5..9; FIFO word width.
DEPTH, 4, FIFO entries; power of two, at least 2.
OVERSAMPLE, 16, prescaler ticks per bit; at least 1.
DIV_W, 16, width of baud_div.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
Tx_EN  in  1  transmitter enable
Tx_WR  in  1  one-cycle write strobe; pushes Tx_DATA into the FIFO
Tx_DATA  in  DATA_W  word to send, LSB first
baud_div  in  DIV_W  prescaler terminal count; bit time = (baud_div+1)*OVERSAMPLE clocks
nbits  in  4  data bits per frame, 5..DATA_W; values outside the range are clamped to DATA_W
parity_mode  in  2  00 none, 01 even, 10 odd, 11 none
stop2  in  1  1 = two stop bits
TxD  out  1  serial line, registered
Tx_BUSY  out  1  high while a frame is on the line
Tx_DONE  out  1  one-cycle pulse at the end of the last stop bit
Tx_FULL  out  1  FIFO full
Tx_EMPTY  out  1  FIFO empty
Tx_LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy
Tx_OVF  out  1  one-cycle pulse when a write is dropped

Behaviour:
- Reset (reset=0, asynchronous): TxD=1, Tx_BUSY=0, Tx_DONE=0, Tx_FULL=0, Tx_EMPTY=1, Tx_LEVEL=0, Tx_OVF=0. FIFO pointers and all counters clear. State=OFF.
- Reset mid-frame: the line returns to 1 immediately. Queued data is lost.
- FIFO write: Tx_WR accepted iff Tx_FULL=0 at that clock edge. An accepted write is stored regardless of Tx_EN.
- FIFO write when full: the write is dropped and Tx_OVF pulses for 1 cycle. This holds even if a pop occurs on the same edge.
- Simultaneous push and pop when neither full nor empty: Tx_LEVEL is unchanged.
- Pointers wrap modulo DEPTH. Tx_FULL/Tx_EMPTY/Tx_LEVEL update in the cycle after the edge.
- State OFF: TxD=1. Go to IDLE when Tx_EN=1.
- State IDLE: TxD=1.
  - If Tx_EN=0, go to OFF.
  - Else if FIFO is not empty: pop the head into the shift register; latch nbits, parity_mode, stop2 and baud_div; clear the prescaler and oversample counters; go to START.
  - TxD falls on the edge entering START, i.e. 1 clock after Tx_EMPTY is seen low in IDLE.
- Bit timing:
  - The prescaler counts 0..baud_div and ticks at baud_div.
  - The oversample counter advances on each tick, 0..OVERSAMPLE-1.
  - The bit ends on a tick with the oversample counter at OVERSAMPLE-1.
  - baud_div=0 means one tick per clock.
- START: TxD=0 for one bit, then go to DATA.
- DATA: TxD=shift[0]; shift right at each bit end. After nbits bits, go to PARITY if parity is enabled, else to STOP.
- PARITY: TxD = XOR of the nbits data bits for even; its inverse for odd. Lasts one bit.
- STOP: TxD=1 for 1 bit, or 2 bits if stop2=1.
  - At the last stop-bit end, Tx_DONE pulses and the state goes to IDLE.
  - If the FIFO is not empty and Tx_EN=1, the next START follows with 1 idle clock only, which is still a valid line.
- Tx_BUSY=1 in START, DATA, PARITY and STOP; 0 otherwise.
- Tx_EN dropped mid-frame: the current frame completes, then IDLE goes to OFF. FIFO contents are retained.
- Config inputs change mid-frame: no effect until the next frame.
- Frame length in clocks = (1 + nbits + P + S) * (baud_div+1) * OVERSAMPLE.
  - P = 1 if parity is enabled, else 0.
  - S = 1 + stop2.

Optional Feature:
UART_TX_BREAK_EN.
- Defined: adds input Tx_BREAK (1 bit) and state BREAK.
  - When Tx_BREAK=1 in IDLE, go to BREAK and hold TxD=0 with Tx_BUSY=1.
  - On Tx_BREAK=0, emit one stop bit of TxD=1, then return to IDLE.
  - Tx_BREAK is ignored mid-frame; it is taken after Tx_DONE.
  - Tx_BREAK has priority over a non-empty FIFO in IDLE.
- Undefined: no port, no state; the line never drives a break.

Test Plan:
1. Reset mid-frame: Tx_EN=1, baud_div=1, OVERSAMPLE=16, nbits=8, parity_mode=01, stop2=0. Write 0xA5. Assert reset=0 during data bit 3 -> TxD=1 immediately, Tx_BUSY=0, Tx_EMPTY=1, Tx_LEVEL=0.
2. Single frame, even parity: same config as scenario 1; write 0xA5.
   - TxD, 32 clocks per bit: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1 (stop).
   - Tx_DONE pulses once 352 clocks after START entry.
3. Odd parity, 7 bits, two stop bits: nbits=7, parity_mode=10, stop2=1; write 0x01.
   - Data bits 1,0,0,0,0,0,0; parity 0; two stop bits.
   - 11 bits = 352 clocks.
4. FIFO fill and overflow: DEPTH=4, Tx_EN=0; write 5 words.
   - Tx_LEVEL=4, Tx_FULL=1, Tx_OVF pulses on the 5th write.
   - Then Tx_EN=1 -> 4 frames back-to-back in write order, 4 Tx_DONE pulses, Tx_EMPTY=1 at the end.
5. Tx_EN drop: deassert Tx_EN during the parity bit with 2 words queued -> the frame completes, the state goes to OFF, TxD=1, Tx_LEVEL=1 retained.
6. No parity, baud_div=0: parity_mode=00, baud_div=0, OVERSAMPLE=1, nbits=5; write 0x1F -> TxD = 0,1,1,1,1,1,1 at 1 clock per bit, Tx_BUSY high for exactly 7 clocks.
